la_readout_streamer: RTL and testbench

- Downstream consumer of the logic analyzer core's capture buffer.
- Once the core raises done, this block walks read offsets 0..2^DEPTH_LOG2-1 on the core's read port and latches each DATA_WIDTH-bit sample.
- It serialises each sample into a byte stream over a valid/ready handshake for a UART or host-link transmitter.
- After the dump it optionally pulses the core's reset to re-arm capture.

---
 rtl/la_readout_streamer.sv | 177 +++++++++++++++++
 tb/tb_la_readout_streamer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_readout_streamer.sv
// la_readout_streamer: once the analyzer core reports la_done, reads every capture-buffer
//   offset and streams each DATA_WIDTH-bit sample out as bytes, MSB first.
// Ports: clk/reset_n; la_done, la_read_addr, la_read_data, la_reset (core side);
//   auto_rearm (config); tx_data/tx_valid/tx_ready (byte stream); busy (status).
// Optional: define RTLA_STREAM_HEADER_EN to prefix every dump with "RTLA" plus the
//   16-bit big-endian sample count minus one.
module la_readout_streamer #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  la_done,
  output logic [DEPTH_LOG2-1:0] la_read_addr,
  input  logic [DATA_WIDTH-1:0] la_read_data,
  output logic                  la_reset,
  input  logic                  auto_rearm,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  // The counter also indexes the 6 header bytes, so never narrower than 3 bits.
  localparam int CNT_W = (BYTES > 8) ? $clog2(BYTES) : 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_SEND   = 3'd3,
    S_REARM  = 3'd4,
`ifdef RTLA_STREAM_HEADER_EN
    S_HEADER = 3'd6,
`endif
    S_HOLD   = 3'd5
  } state_t;

`ifdef RTLA_STREAM_HEADER_EN
  localparam logic [15:0] SAMPLES_M1 = 16'((1 << DEPTH_LOG2) - 1);

  function automatic logic [7:0] hdr_byte(input logic [CNT_W-1:0] idx);
    case (idx)
      CNT_W'(0): hdr_byte = 8'h52;
      CNT_W'(1): hdr_byte = 8'h54;
      CNT_W'(2): hdr_byte = 8'h4C;
      CNT_W'(3): hdr_byte = 8'h41;
      CNT_W'(4): hdr_byte = SAMPLES_M1[15:8];
      default:   hdr_byte = SAMPLES_M1[7:0];
    endcase
  endfunction
`endif

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    la_reset_q, la_reset_d;
  logic                    busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    la_reset_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (la_done) begin
`ifdef RTLA_STREAM_HEADER_EN
          state_d    = S_HEADER;
          cnt_d      = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = hdr_byte('0);
`else
          state_d    = S_FETCH;
`endif
        end
      end
`ifdef RTLA_STREAM_HEADER_EN
      // tx_valid is always high in HEADER; cnt_q is the index of the byte on tx_data.
      S_HEADER: begin
        if (tx_ready) begin
          if (!la_done) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else if (cnt_q == CNT_W'(5)) begin
            tx_valid_d = 1'b0;
            state_d    = S_FETCH;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            tx_data_d = hdr_byte(cnt_q + 1'b1);
          end
        end
      end
`endif
      // Core samples la_read_addr at the end of FETCH; data is readable during WAIT.
      S_FETCH: state_d = la_done ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (!la_done) begin
          state_d = S_IDLE;
        end else begin
          tx_data_d  = la_read_data[DATA_WIDTH-1 -: 8];
          shreg_d    = la_read_data << 8;
          cnt_d      = CNT_W'(BYTES - 1);
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end
      end
      // shreg_q holds the not-yet-presented bytes, next one in the top byte lane.
      S_SEND: begin
        if (tx_ready) begin
          if (!la_done) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else if (cnt_q != '0) begin
            tx_data_d = shreg_q[DATA_WIDTH-1 -: 8];
            shreg_d   = shreg_q << 8;
            cnt_d     = cnt_q - 1'b1;
          end else if (!(&addr_q)) begin
            addr_d     = addr_q + 1'b1;
            tx_valid_d = 1'b0;
            state_d    = S_FETCH;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = S_REARM;
          end
        end
      end
      S_REARM: begin
        la_reset_d = auto_rearm;
        state_d    = S_HOLD;
      end
      // Stay here until the core drops la_done so the same buffer is not dumped twice.
      S_HOLD: if (!la_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      la_reset_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      la_reset_q <= la_reset_d;
      busy_q     <= busy_d;
    end
  end

  assign la_read_addr = addr_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign la_reset     = la_reset_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_la_readout_streamer.sv
module tb_la_readout_streamer;

  localparam int DW    = 128;
  localparam int AW    = 9;
  localparam int BYTES = DW / 8;
  localparam int NW    = 1 << AW;
`ifdef RTLA_STREAM_HEADER_EN
  localparam int HDR_N = 6;
`else
  localparam int HDR_N = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          la_done;
  logic [AW-1:0] la_read_addr;
  logic [DW-1:0] la_read_data = '0;
  logic          la_reset;
  logic          auto_rearm;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          busy;

  la_readout_streamer #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW)) dut (
    .clk(clk), .reset_n(reset_n), .la_done(la_done), .la_read_addr(la_read_addr),
    .la_read_data(la_read_data), .la_reset(la_reset), .auto_rearm(auto_rearm),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pat     = 0;
  int rdy_mode = 0;   // 0: always ready, 1: ~30% random, 2: ready while n_acc < rdy_limit
  int rdy_limit = 0;
  bit in_dump = 0;

  // Written only by the monitor.
  int n_acc = 0, pulses = 0, pulse_hi = 0, pulse_cyc = 0, stab_err = 0, busy_err = 0;
  bit prev_hold = 0, prev_lr = 0;
  logic [7:0] prev_data = '0;

  logic [7:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a, input int p);
    if (p == 1 && a == '0) return 128'h0123456789ABCDEF0123456789ABCDEF;
    return {BYTES{a[7:0]}};
  endfunction

  // Core read port model: one clock of read latency.
  always @(posedge clk) la_read_data <= word_of(la_read_addr, pat);

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom_range(99) < 30);
      default: tx_ready = (n_acc < rdy_limit);
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: inputs and outputs are stable at negedge; a byte with valid&&ready here
  // is accepted at the following posedge.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold = 0;
      prev_lr   = 0;
    end else begin
      if (prev_hold && (!tx_valid || tx_data !== prev_data)) stab_err++;
      if (tx_valid && tx_ready) begin
        n_acc++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data);
        end else begin
          check("stream_byte", {24'h0, tx_data}, {24'h0, sb.pop_front()});
        end
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (la_reset) begin
        pulse_hi++;
        if (!prev_lr) begin
          pulses++;
          pulse_cyc = cyc;
        end
      end
      prev_lr = la_reset;
      if (in_dump && !busy) busy_err++;
    end
  end

  task automatic push_dump(input int p, input int nmax);
    logic [DW-1:0] w;
    int cnt;
`ifdef RTLA_STREAM_HEADER_EN
    logic [7:0] hb [6];
    hb = '{8'h52, 8'h54, 8'h4C, 8'h41, 8'h01, 8'hFF};
`endif
    cnt = 0;
`ifdef RTLA_STREAM_HEADER_EN
    for (int i = 0; i < 6; i++) if (cnt < nmax) begin sb.push_back(hb[i]); cnt++; end
`endif
    for (int n = 0; n < NW; n++) begin
      w = word_of(n[AW-1:0], p);
      for (int b = BYTES - 1; b >= 0; b--)
        if (cnt < nmax) begin sb.push_back(w[b*8 +: 8]); cnt++; end
    end
  endtask

  typedef struct {
    logic ar;
    int   mode;
    int   p;
    logic chk_lat;
    int   exp_pulses;
    int   exp_bytes;
  } row_t;
  row_t rows[3];

  int acc0, pul0, hi0, stab0, berr0, t0;
  bit ok;

  task automatic wait_stream_done(input int bound, output bit done);
    done = 0;
    for (int i = 0; i < bound; i++) begin
      if (sb.size() == 0 && !tx_valid) begin done = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic snap();
    acc0 = n_acc; pul0 = pulses; hi0 = pulse_hi; stab0 = stab_err; berr0 = busy_err;
  endtask

  task automatic finish_dump(input int exp_pulses, input int exp_bytes, input logic chk_lat);
    wait_stream_done(40000, ok);
    check("dump_done_in_time", {31'h0, ok}, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    check("byte_count", n_acc - acc0, exp_bytes);
    check("rearm_pulses", pulses - pul0, exp_pulses);
    check("rearm_width", pulse_hi - hi0, exp_pulses);
    if (chk_lat) check_rng("rearm_latency", pulse_cyc - t0, 9216 + HDR_N - 2, 9216 + HDR_N + 2);
    check("hold_busy", {31'h0, busy}, 32'h1);
    check("hold_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("stall_stability_errs", stab_err - stab0, 0);
    check("busy_gaps", busy_err - berr0, 0);
    in_dump = 0;
    la_done = 0;
    @(posedge clk); #1;
    check("busy_after_done_drop", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    check("idle_addr", {23'h0, la_read_addr}, 32'h0);
    check("idle_la_reset", {31'h0, la_reset}, 32'h0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{1'b1, 0, 0, 1'b1, 1, NW*BYTES + HDR_N};   // fast sink, auto re-arm
    rows[1] = '{1'b1, 1, 0, 1'b0, 1, NW*BYTES + HDR_N};   // 30% random backpressure
    rows[2] = '{1'b0, 0, 1, 1'b0, 0, NW*BYTES + HDR_N};   // no re-arm, 0x0123..EF word 0

    reset_n = 1'b0; la_done = 1'b0; auto_rearm = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_addr", {23'h0, la_read_addr}, 32'h0);
    check("rst_la_reset", {31'h0, la_reset}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_done_busy", {31'h0, busy}, 32'h0);

    for (int r = 0; r < 3; r++) begin
      auto_rearm = rows[r].ar; rdy_mode = rows[r].mode; pat = rows[r].p;
      snap();
      push_dump(rows[r].p, 1 << 30);
      la_done = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      in_dump = 1;
      finish_dump(rows[r].exp_pulses, rows[r].exp_bytes, rows[r].chk_lat);
    end

    // Abort: la_done drops while the 5th byte of word 3 is stalled.
    auto_rearm = 1'b1; pat = 0;
    snap();
    rdy_limit = acc0 + HDR_N + 52;
    rdy_mode = 2;
    push_dump(0, HDR_N + 53);
    la_done = 1'b1;
    @(posedge clk); #1;
    in_dump = 1;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (n_acc - acc0 == HDR_N + 52 && tx_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    check("abort_reach_word3", {31'h0, ok}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    check("abort_pending_valid", {31'h0, tx_valid}, 32'h1);
    check("abort_pending_data", {24'h0, tx_data}, 32'h03);
    in_dump = 0;
    la_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_byte_held", {31'h0, tx_valid}, 32'h1);
    rdy_limit = rdy_limit + 1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_bytes", n_acc - acc0, HDR_N + 53);
    check("abort_sb_empty", sb.size(), 0);
    check("abort_no_rearm", pulses - pul0, 0);
    check("abort_stability", stab_err - stab0, 0);

    // Asynchronous reset in the middle of SEND, then a fresh dump.
    rdy_mode = 0; auto_rearm = 1'b1;
    @(posedge clk); #1;
    snap();
    push_dump(0, 1 << 30);
    la_done = 1'b1;
    @(posedge clk); #1;
    in_dump = 1;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (n_acc - acc0 >= HDR_N + 20 && tx_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    check("arst_reach_send", {31'h0, ok}, 32'h1);
    #2;
    in_dump = 0;
    reset_n = 1'b0;
    #1;
    check("arst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("arst_addr", {23'h0, la_read_addr}, 32'h0);
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_tx_data", {24'h0, tx_data}, 32'h0);
    sb.delete();
    @(posedge clk); #1;
    push_dump(0, 1 << 30);
    snap();
    reset_n = 1'b1;
    @(posedge clk); #1;
    in_dump = 1;
    finish_dump(1, NW*BYTES + HDR_N, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
